// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: one main register plus a one-entry skid buffer.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W  = 64,
  parameter logic [DATA_W-1:0]    NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              stats_clr,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
);

  // state   | meaning
  // S_EMPTY | no entry held, main = NOP_VAL
  // S_ONE   | main holds the only entry
  // S_FULL  | main holds the older entry, skid the younger
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, take;

  always_comb begin
    in_ready  = ~freeze & (state_q != S_FULL);
    out_valid = ~freeze & (state_q != S_EMPTY);
    accept    = in_valid & in_ready;
    take      = out_valid & out_ready;
    out_data  = main_q;
  end

  // freeze needs no explicit term here: it already forces accept and take low.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (accept && take) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (take) begin
            state_d = S_EMPTY;
            main_d  = NOP_VAL;
          end
        end
        S_FULL: begin
          if (take) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; stats_clr wins over a same-cycle increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stats_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if ((state_q != S_EMPTY) && !take && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (out_ready && !freeze && (state_q == S_EMPTY) && (bubble_cnt_q != 16'hFFFF))
        bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stall_cnt        = '0;
  assign bubble_cnt       = '0;
`endif

endmodule
